// File: rtl/cpu_stack.sv
// Writeback-side operand stack: pop-then-push per cycle, registered top-two view and occupancy.
// Optional feature: define CPU_STACK_FAULT_EN to suppress faulting operations and raise a sticky fault.
module cpu_stack #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st__pop_5a,
    input  logic [10:0]                st__to_pop_5a,
    input  logic                       st__push_5a,
    input  logic [WIDTH-1:0]           st__to_push_5a,
    output logic [WIDTH-1:0]           st__top0,
    output logic [WIDTH-1:0]           st__top1,
    output logic [$clog2(DEPTH):0]     st__depth,
    output logic                       st__empty,
    output logic                       st__full,
    output logic                       st__fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;
    localparam int unsigned CW = 12;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [DW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] top0_q, top0_d;
    logic [WIDTH-1:0] top1_q, top1_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             fault_q, fault_d;

    logic [CW-1:0]    pop_n;
    logic [CW-1:0]    base;
    logic [CW-1:0]    sum;
    logic             underflow;
    logic             overflow;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    // Next-state: resolve pop/push, then derive the registered top-of-stack view.
    always_comb begin
        pop_n     = st__pop_5a ? CW'(st__to_pop_5a) : '0;
        underflow = pop_n > CW'(depth_q);
        base      = underflow ? '0 : CW'(depth_q) - pop_n;
        sum       = base + CW'(st__push_5a);
        overflow  = !underflow && (sum > CW'(DEPTH));

        depth_d = depth_q;
        fault_d = fault_q;
        wr_en   = 1'b0;
        wr_idx  = AW'(base);

`ifdef CPU_STACK_FAULT_EN
        if (underflow || overflow) begin
            fault_d = 1'b1;
        end else begin
            depth_d = DW'(sum);
            wr_en   = st__push_5a;
        end
`else
        fault_d = 1'b0;
        if (overflow) begin
            depth_d = DW'(DEPTH);
        end else begin
            depth_d = DW'(sum);
            wr_en   = st__push_5a;
        end
`endif

        // The written slot is always depth_d-1, so top1 only ever reads old contents.
        if (depth_d == '0) begin
            top0_d = '0;
        end else if (wr_en) begin
            top0_d = st__to_push_5a;
        end else begin
            top0_d = mem[AW'(depth_d - DW'(1))];
        end

        if (depth_d < DW'(2)) begin
            top1_d = '0;
        end else begin
            top1_d = mem[AW'(depth_d - DW'(2))];
        end

        empty_d = (depth_d == '0);
        full_d  = (depth_d == DW'(DEPTH));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            top0_q  <= '0;
            top1_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            depth_q <= depth_d;
            top0_q  <= top0_d;
            top1_q  <= top1_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            fault_q <= fault_d;
        end
    end

    // Entry storage; never cleared, stale slots are masked by depth.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_idx] <= st__to_push_5a;
        end
    end

    assign st__top0  = top0_q;
    assign st__top1  = top1_q;
    assign st__depth = depth_q;
    assign st__empty = empty_q;
    assign st__full  = full_q;
    assign st__fault = fault_q;

endmodule
